// File: rtl/tpc_sram_pkg.sv
// Shared scratchpad constants and address-decode helpers for the TPC SRAM banks.
// The DMA and the loaders use the same helpers, so they all agree on the
// low-order bank interleave.
package tpc_sram_pkg;

    localparam int NUM_BANKS_DEF = 4;
    localparam int WIDTH_DEF     = 256;
    localparam int ROW_W_DEF     = 8;
    localparam int ADDR_W_DEF    = 20;

    // Bank index: the low address bits. num_banks is a power of two.
    function automatic logic [31:0] bank_sel(input logic [31:0] addr, input int num_banks);
        return addr & (32'(num_banks) - 32'd1);
    endfunction

    // Row index: the row_w bits directly above the bank bits.
    function automatic logic [31:0] row_sel(input logic [31:0] addr, input int bank_w, input int row_w);
        logic [31:0] mask;
        mask = (32'd1 << row_w) - 32'd1;
        return (addr >> bank_w) & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own pointer. The search starts at the pointer
// and wraps. After a grant the pointer moves to one past the winner.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] cand_idx_s;
    logic             found_s;
    logic             hit_s;

    // Find the first active request at or after the pointer, wrapping
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        found_s    = 1'b0;
        hit_s      = 1'b0;
        cand_idx_s = '0;
        for (int k = 0; k < N; k++) begin
            cand_idx_s        = IDX_W'((int'(ptr_r) + k) % N);
            hit_s             = !found_s && req[cand_idx_s];
            grant[cand_idx_s] = grant[cand_idx_s] | hit_s;
            grant_idx         = hit_s ? cand_idx_s : grant_idx;
            found_s           = found_s | hit_s;
        end
    end

    // Move the pointer past the winner on every grant taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (advance && found_s) begin
            ptr_r <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Banked scratchpad arbiter. Each requester addresses one bank through the
// low-order interleave. Every bank has its own round-robin arbiter, so
// different banks are granted in parallel. The winner drives the bank port
// combinationally. Read data returns exactly one cycle after the handshake.
module sram_bank_arbiter
    import tpc_sram_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ROW_W     = ROW_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [NUM_REQ*WIDTH-1:0]   rsp_rdata,
    output logic [NUM_BANKS-1:0]       bank_en,
    output logic [NUM_BANKS-1:0]       bank_we,
    output logic [NUM_BANKS*ROW_W-1:0] bank_addr,
    output logic [NUM_BANKS*WIDTH-1:0] bank_wdata,
    input  logic [NUM_BANKS*WIDTH-1:0] bank_rdata,
    output logic [NUM_REQ*16-1:0]      stall_cnt
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][31:0]          bank_ext_s;
    logic [NUM_REQ-1:0][31:0]          row_ext_s;
    logic                              unused_ext_s;
    logic [NUM_REQ-1:0][BANK_W-1:0]    req_bank_s;
    logic [NUM_REQ-1:0][ROW_W-1:0]     req_row_s;
    logic [NUM_BANKS-1:0][NUM_REQ-1:0] cand_s;
    logic [NUM_BANKS-1:0][NUM_REQ-1:0] grant_s;
    logic [NUM_BANKS-1:0][IDX_W-1:0]   win_idx_s;
    logic [NUM_BANKS-1:0]              busy_s;
    logic                              sel_s;
    logic [NUM_REQ-1:0]                tag_vld_r;
    logic [NUM_REQ-1:0][BANK_W-1:0]    tag_bank_r;
    logic [NUM_REQ-1:0][15:0]          stall_r;

    // Decode each requester's bank and row. Higher address bits are don't-care.
    always_comb begin
        bank_ext_s = '0;
        row_ext_s  = '0;
        req_bank_s = '0;
        req_row_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bank_ext_s[i] = bank_sel(32'(req_addr[i*ADDR_W +: ADDR_W]), NUM_BANKS);
            row_ext_s[i]  = row_sel(32'(req_addr[i*ADDR_W +: ADDR_W]), BANK_W, ROW_W);
            req_bank_s[i] = bank_ext_s[i][BANK_W-1:0];
            req_row_s[i]  = row_ext_s[i][ROW_W-1:0];
        end
    end

    assign unused_ext_s = ^{bank_ext_s, row_ext_s};

    // Build the per-bank candidate sets from the valid requests
    always_comb begin
        cand_s = '0;
        busy_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand_s[b][i] = req_valid[i] && (req_bank_s[i] == BANK_W'(b));
            end
            busy_s[b] = |cand_s[b];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rr_arbiter #(.N(NUM_REQ)) u_rr (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (cand_s[b]),
            .advance   (busy_s[b]),
            .grant     (grant_s[b]),
            .grant_idx (win_idx_s[b])
        );
    end

    // Drive ready and the bank ports from each bank's winner; idle banks read as zero
    always_comb begin
        req_ready  = '0;
        bank_en    = '0;
        bank_we    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        sel_s      = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_ready  = req_ready | grant_s[b];
            bank_en[b] = busy_s[b];
            for (int i = 0; i < NUM_REQ; i++) begin
                sel_s      = busy_s[b] && (win_idx_s[b] == IDX_W'(i));
                bank_we[b] = bank_we[b] | (sel_s & req_we[i]);
                bank_addr[b*ROW_W +: ROW_W]  = bank_addr[b*ROW_W +: ROW_W] |
                                               (sel_s ? req_row_s[i] : '0);
                bank_wdata[b*WIDTH +: WIDTH] = bank_wdata[b*WIDTH +: WIDTH] |
                                               (sel_s ? req_wdata[i*WIDTH +: WIDTH] : '0);
            end
        end
    end

    // Remember which bank each read was granted on, so its data can be routed back next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_r  <= '0;
            tag_bank_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                tag_vld_r[i]  <= req_ready[i] & ~req_we[i];
                tag_bank_r[i] <= (req_ready[i] & ~req_we[i]) ? req_bank_s[i] : tag_bank_r[i];
            end
        end
    end

    // Route bank read data to the tagged requester; outputs are zero when there is no response
    always_comb begin
        rsp_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rsp_rdata[i*WIDTH +: WIDTH] = rsp_rdata[i*WIDTH +: WIDTH] |
                    ((tag_vld_r[i] && (tag_bank_r[i] == BANK_W'(b))) ?
                     bank_rdata[b*WIDTH +: WIDTH] : '0);
            end
        end
    end

    // Count cycles where a request waits without a grant; saturate at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stall_r[i] <= (req_valid[i] && !req_ready[i] && (stall_r[i] != 16'hFFFF)) ?
                              stall_r[i] + 16'd1 : stall_r[i];
            end
        end
    end

    assign rsp_valid = tag_vld_r;
    assign stall_cnt = stall_r;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a behavioural one-cycle SRAM per bank.
module tb_sram_bank_arbiter;

    localparam int NR = 4;
    localparam int NB = 4;
    localparam int W  = 256;
    localparam int AW = 20;
    localparam int RW = 8;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*W-1:0] req_wdata;
    logic [NR-1:0]   rsp_valid;
    logic [NR*W-1:0] rsp_rdata;
    logic [NB-1:0]   bank_en;
    logic [NB-1:0]   bank_we;
    logic [NB*RW-1:0] bank_addr;
    logic [NB*W-1:0] bank_wdata;
    logic [NB*W-1:0] bank_rdata;
    logic [NR*16-1:0] stall_cnt;

    logic            preload;
    logic [W-1:0]    mem [NB][256];
    logic [3:0]      exp_oh;
    int              vec_cnt;
    int              miscmp_cnt;
    int              g3_cnt;

    sram_bank_arbiter #(
        .NUM_REQ(NR), .NUM_BANKS(NB), .WIDTH(W), .ADDR_W(AW), .ROW_W(RW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Initial SRAM contents: {BEEF, bank, row}, except bank 0 row 4.
    function automatic logic [W-1:0] init_word(input int b, input int r);
        logic [W-1:0] v;
        v        = '0;
        v[31:16] = 16'hBEEF;
        v[15:8]  = 8'(b);
        v[7:0]   = 8'(r);
        if (b == 0 && r == 4) v = 256'h0403_0201;
        return v;
    endfunction

    // Behavioural banks: write at the edge, registered read data.
    always @(posedge clk) begin
        if (preload) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < 256; r++)
                    mem[b][r] <= init_word(b, r);
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_en[b]) begin
                    if (bank_we[b]) mem[b][bank_addr[b*RW +: RW]] <= bank_wdata[b*W +: W];
                    else            bank_rdata[b*W +: W] <= mem[b][bank_addr[b*RW +: RW]];
                end
            end
        end
    end

    task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr,
                           input logic [W-1:0] wd);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = addr;
        req_wdata[i*W +: W]   = wd;
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Schedule that keeps requester 3 losing on banks 2/3 every cycle.
    task automatic drive_sat(input int p);
        clr_req();
        case (p)
            0: begin set_req(1, 1'b0, 20'h02, '0); set_req(3, 1'b0, 20'h02, '0); set_req(0, 1'b0, 20'h03, '0); end
            1: begin set_req(2, 1'b0, 20'h02, '0); set_req(3, 1'b0, 20'h02, '0); end
            2: begin set_req(0, 1'b0, 20'h02, '0); set_req(1, 1'b0, 20'h03, '0); set_req(3, 1'b0, 20'h03, '0); end
            default: begin set_req(2, 1'b0, 20'h03, '0); set_req(3, 1'b0, 20'h03, '0); end
        endcase
    endtask

    initial begin
        vec_cnt    = 0;
        miscmp_cnt = 0;
        g3_cnt     = 0;
        rst_n      = 1'b0;
        preload    = 1'b1;
        clr_req();
        tick();
        tick();
        preload = 1'b0;

        // Reset state
        check_vec("rst_ready", req_ready, 4'b0000);
        check_vec("rst_bank_en", bank_en, 4'b0000);
        check_vec("rst_bank_addr", bank_addr, 32'h0);
        check_vec("rst_rsp_valid", rsp_valid, 4'b0000);
        check_vec("rst_stall", stall_cnt, 64'h0);
        rst_n = 1'b1;
        tick();

        // Conflict fairness: all four read bank 1 for 8 cycles
        for (int c = 0; c < 8; c++) begin
            clr_req();
            for (int i = 0; i < 4; i++) set_req(i, 1'b0, 20'(4 * i + 1), '0);
            #2;
            exp_oh = 4'b0001 << (c % 4);
            check_vec("rr_ready", req_ready, exp_oh);
            if (c > 0) begin
                exp_oh = 4'b0001 << ((c - 1) % 4);
                check_vec("rr_rsp_valid", rsp_valid, exp_oh);
            end
            tick();
        end
        clr_req();
        #2;
        check_vec("rr_last_rsp_valid", rsp_valid, 4'b1000);
        check_vec("rr_last_rdata3", rsp_rdata[3*W +: W], 256'hBEEF_0103);
        for (int i = 0; i < 4; i++) check_vec("rr_stall", stall_cnt[i*16 +: 16], 16'd6);
        tick();

        // Single read: req0 addr 0x10 -> bank 0 row 4
        set_req(0, 1'b0, 20'h10, '0);
        #2;
        check_vec("single_ready", req_ready, 4'b0001);
        check_vec("single_bank_en", bank_en, 4'b0001);
        check_vec("single_bank_addr0", bank_addr[7:0], 8'h04);
        tick();
        check_vec("single_rsp_valid", rsp_valid, 4'b0001);
        check_vec("single_rdata0", rsp_rdata[0 +: W], 256'h0403_0201);
        check_vec("single_rdata1_zero", rsp_rdata[W +: W], 256'h0);
        clr_req();

        // Parallel: four requesters on four banks, row 8
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 20'(32 + i), '0);
        #2;
        check_vec("par_ready", req_ready, 4'b1111);
        check_vec("par_bank_en", bank_en, 4'b1111);
        check_vec("par_bank_we", bank_we, 4'b0000);
        check_vec("par_bank_addr", bank_addr, 32'h0808_0808);
        tick();
        check_vec("par_rsp_valid", rsp_valid, 4'b1111);
        check_vec("par_rdata0", rsp_rdata[0*W +: W], 256'hBEEF_0008);
        check_vec("par_rdata1", rsp_rdata[1*W +: W], 256'hBEEF_0108);
        check_vec("par_rdata2", rsp_rdata[2*W +: W], 256'hBEEF_0208);
        check_vec("par_rdata3", rsp_rdata[3*W +: W], 256'hBEEF_0308);
        clr_req();

        // Write then read: req2 writes 0xDEAD to 0x05 (bank 1 row 1)
        set_req(2, 1'b1, 20'h05, 256'hDEAD);
        #2;
        check_vec("wr_ready", req_ready, 4'b0100);
        check_vec("wr_bank_en", bank_en, 4'b0010);
        check_vec("wr_bank_we", bank_we, 4'b0010);
        check_vec("wr_bank_addr1", bank_addr[15:8], 8'h01);
        check_vec("wr_bank_wdata1", bank_wdata[W +: W], 256'hDEAD);
        tick();
        check_vec("wr_no_rsp", rsp_valid, 4'b0000);
        clr_req();
        set_req(2, 1'b0, 20'h05, '0);
        #2;
        check_vec("rd_ready", req_ready, 4'b0100);
        tick();
        check_vec("rd_rsp_valid", rsp_valid, 4'b0100);
        check_vec("rd_rdata2", rsp_rdata[2*W +: W], 256'hDEAD);
        clr_req();

        // Reset mid-read: bank 0 pointer is 1 at this point
        set_req(1, 1'b0, 20'h02, '0);
        #2;
        check_vec("rstmid_ready", req_ready, 4'b0010);
        #1;
        rst_n = 1'b0;
        clr_req();
        tick();
        check_vec("rstmid_rsp_valid", rsp_valid, 4'b0000);
        check_vec("rstmid_rdata1", rsp_rdata[W +: W], 256'h0);
        check_vec("rstmid_stall", stall_cnt, 64'h0);
        rst_n = 1'b1;
        tick();
        check_vec("rstmid_no_late_rsp", rsp_valid, 4'b0000);
        set_req(0, 1'b0, 20'h00, '0);
        set_req(1, 1'b0, 20'h04, '0);
        #2;
        check_vec("rstmid_ptr0_ready", req_ready, 4'b0001);
        tick();
        check_vec("rstmid_conf_rsp", rsp_valid, 4'b0001);
        check_vec("rstmid_conf_rdata0", rsp_rdata[0 +: W], 256'hBEEF_0000);
        check_vec("rstmid_stall1", stall_cnt[16 +: 16], 16'd1);
        clr_req();

        // Saturation: bootstrap bank 2 pointer to 1 and bank 3 pointer to 3
        set_req(0, 1'b0, 20'h02, '0);
        set_req(2, 1'b0, 20'h03, '0);
        #2;
        check_vec("sat_boot_ready", req_ready, 4'b0101);
        tick();
        for (int k = 0; k < 65539; k++) begin
            drive_sat(k % 4);
            #2;
            if (req_ready[3]) g3_cnt++;
            tick();
            if (k == 65533) check_vec("stall3_pre_sat", stall_cnt[48 +: 16], 16'hFFFE);
            if (k == 65534) check_vec("stall3_sat", stall_cnt[48 +: 16], 16'hFFFF);
        end
        clr_req();
        check_vec("stall3_hold", stall_cnt[48 +: 16], 16'hFFFF);
        check_vec("sat_req3_grants", 32'(g3_cnt), 32'd0);
        check_vec("sat_stall0", stall_cnt[0 +: 16], 16'd0);
        check_vec("sat_stall1", stall_cnt[16 +: 16], 16'd1);
        check_vec("sat_stall2", stall_cnt[32 +: 16], 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule

// File: doc/sram_bank_arbiter.md
Name: sram_bank_arbiter

Overview:
Shares the tensor processing cluster's banked scratchpad SRAM among several requesters: systolic-array loader, result writer, VPU, DMA/NoC. Each request word address is low-order interleaved across banks, so matrix row r of a 4-row tile sits in bank r at the same row index. The arbiter grants at most one requester per bank per cycle, with independent round-robin per bank. It drives the bank ports and routes 1-cycle read data back to the winning requester. It sits between the TPC engines and the sram bank instances.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
NUM_BANKS, 4, number of SRAM banks (power of two)
WIDTH, 256, data word width in bits
ADDR_W, 20, requester word-address width
ROW_W, 8, bank row-index width (log2 SRAM_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  grant this cycle (combinational from valid/pointers)
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  word address, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*WIDTH  write data
rsp_valid  out  NUM_REQ  read data valid (registered)
rsp_rdata  out  NUM_REQ*WIDTH  read data
bank_en  out  NUM_BANKS  bank access enable
bank_we  out  NUM_BANKS  bank write enable
bank_addr  out  NUM_BANKS*ROW_W  bank row index
bank_wdata  out  NUM_BANKS*WIDTH  bank write data
bank_rdata  in  NUM_BANKS*WIDTH  bank read data, valid 1 cycle after bank_en & !bank_we
stall_cnt  out  NUM_REQ*16  per-requester saturating count of valid-but-not-ready cycles

Behaviour:
- Address map: bank = addr[log2(NUM_BANKS)-1:0]; row = addr[log2(NUM_BANKS) +: ROW_W]. Higher address bits are ignored.
- Per bank b: candidates are requesters with req_valid=1 whose address selects b. A round-robin arbiter picks one winner. Search starts at rr_ptr[b]; lowest index at or after the pointer wins, wrapping.
- Grant cycle: req_ready[winner]=1 and the transfer occurs (valid&ready) in the same cycle. bank_en/we/addr/wdata are driven combinationally from the winner. With no candidates, bank_en=0 and the other bank outputs are 0.
- rr_ptr[b] <= winner+1 (mod NUM_REQ) on each grant. No grant means no change.
- Read response: on a read grant, the registered tag {valid, bank} is stored for that requester. Next cycle rsp_valid[i]=1 and rsp_rdata[i] = bank_rdata[tagged bank]. Read latency is exactly 1 cycle after the handshake. rsp_rdata is 0 when rsp_valid=0.
- Writes produce no response. Data is in the bank at the next edge. A read of the same row on the next cycle returns the new data.
- Each requester targets one bank, so it receives at most one grant and one response per cycle. Back-to-back reads give rsp_valid on consecutive cycles.
- A requester must hold valid/we/addr/wdata stable until ready; the arbiter does not register requests.
- Different banks are granted in parallel in one cycle. All NUM_REQ requesters on distinct banks are all granted.
- stall_cnt[i] increments on each cycle with req_valid[i]&!req_ready[i]. It saturates at 16'hFFFF.
- Reset (async, rst_n=0): rr_ptr=0, response tags cleared, rsp_valid=0, rsp_rdata=0, stall_cnt=0. Combinational outputs follow inputs with pointers at 0. A read in flight at reset assertion is dropped; no rsp_valid after release.

Decomposition:
- Package tpc_sram_pkg: NUM_BANKS, WIDTH, ROW_W defaults; a bank_sel function (addr -> bank) and a row_sel function (addr -> row), shared with the DMA and the loaders.
- Sub-module rr_arbiter (parameter N): inputs req[N], advance; outputs grant one-hot[N], grant_idx. It holds its own pointer register with async active-low reset. It is instantiated once per bank.

Test Plan:
- Single read: req0 reads addr 0x10 (bank 0, row 4) with mem=0x...04030201 -> req_ready0=1 same cycle; next cycle rsp_valid0=1, rsp_rdata0=0x...04030201.
- Parallel: req0..3 read addrs 0x20,0x21,0x22,0x23 -> all four ready in one cycle; bank_en=4'b1111, bank_addr all 8; four responses next cycle.
- Conflict fairness: req0..3 all read bank 1 continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each stall_cnt=6 (valid 8 cycles, 2 grants).
- Write then read: req2 writes 0xDEAD to addr 0x05 (bank 1, row 1), req2 reads 0x05 next cycle -> rsp_rdata2=0xDEAD one cycle later.
- Reset mid-read: grant read to req1, assert rst_n=0 before the next edge -> rsp_valid=0, rr_ptr=0, stall_cnt=0; after release a 2-way conflict on bank 0 grants req0 first.
- Saturation: hold req3 blocked 70000 cycles (req0 hogging bank 2 via higher-priority pointer reset each time) -> stall_cnt3 stops at 0xFFFF.
